data_memory_ctrl: RTL and testbench

//  Parametrised data memory with RV32I load/store size handling, byte-lane writes,

---
 rtl/data_memory_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with RV32I load/store sizing, byte-lane writes,
// load extension, fault detection and programmable wait states.
module data_memory_ctrl #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [31:0]        rsp_rdata_q;
  logic [31:0]        mem_q [DEPTH];

  logic               accept;
  logic               enter_resp;
  logic               eff_we;
  logic [2:0]         eff_f3;
  logic [31:0]        eff_addr;
  logic [31:0]        eff_wdata;
  logic [32:0]        diff;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic               misalign;
  logic               illegal;
  logic               out_of_range;
  logic               fault;
  logic [31:0]        word;
  logic [31:0]        shifted;
  logic [31:0]        load_val;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Select the request being executed: live inputs in IDLE (zero-latency path), latched copy otherwise
  always_comb begin
    accept     = (state_q == S_IDLE) && req_valid;
    enter_resp = (accept && (LATENCY == 0)) || ((state_q == S_WAIT) && (cnt_q == '0));
    if (state_q == S_IDLE) begin
      eff_we    = req_we;
      eff_f3    = req_funct3;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end else begin
      eff_we    = we_q;
      eff_f3    = f3_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
  end

  // Decode size, byte lanes, faults and the extended load value
  always_comb begin
    diff     = {1'b0, eff_addr} - {1'b0, BASE_ADDR};
    idx      = diff[IDX_W+1:2];
    be       = 4'b0000;
    wlanes   = eff_wdata;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (eff_f3)
      3'b000, 3'b100: begin
        be      = 4'b0001 << diff[1:0];
        wlanes  = {4{eff_wdata[7:0]}};
        illegal = eff_we && eff_f3[2];
      end
      3'b001, 3'b101: begin
        be       = diff[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{eff_wdata[15:0]}};
        misalign = diff[0];
        illegal  = eff_we && eff_f3[2];
      end
      3'b010: begin
        be       = 4'b1111;
        misalign = |diff[1:0];
      end
      default: illegal = 1'b1;
    endcase
    // Range check uses the full offset so high addresses cannot alias into the array
    out_of_range = diff[32] || (diff[31:2] >= 30'(DEPTH));
    fault        = illegal || misalign || out_of_range;

    word    = mem_q[idx];
    shifted = word >> {diff[1:0], 3'b000};
    case (eff_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = word;
    endcase
  end

  // Commit store lanes on the edge that enters RESP; faults and reset suppress the write
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && eff_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  // Request FSM plus registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp && fault;
      rsp_rdata_q <= (enter_resp && !fault && !eff_we) ? load_val : 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three builds (LATENCY 1, 0, 3) checked against a
// byte-array reference model, a directed vector table and reset/hold sequences.
module tb_data_memory_ctrl;

  localparam int unsigned NDUT  = 3;
  localparam int unsigned DEPTH = 64;
  localparam longint      BASE  = 0;

  logic        clk = 1'b0;
  logic        rst        [NDUT];
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_we     [NDUT];
  logic [2:0]  req_funct3 [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        rsp_valid  [NDUT];
  logic [31:0] rsp_rdata  [NDUT];
  logic        rsp_err    [NDUT];

  logic [7:0]  mb [NDUT][4*DEPTH];
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_memory_ctrl #(
      .DEPTH    (DEPTH),
      .BASE_ADDR(32'h0000_0000),
      .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", name);
  endtask

  // Reference: memory as bytes, access rules applied directly from the RV32I size table
  function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    int size;
    longint off;
    longint unsigned v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    off = longint'({32'h0, addr}) - BASE;
    er  = (size == 0) || (we && f3[2]) || ((addr % size) != 0) ||
          (off < 0) || (off >= 4 * DEPTH);
    rd  = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[d][off + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mb[d][off + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 1);
      rd = v[31:0];
    end
  endfunction

  // Issue one request, track the handshake and collect the response
  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int ready_low, output int pulses);
    int n;
    rd = 32'h0; er = 1'b0; lat = -1; ready_low = 0; pulses = 0;
    @(negedge clk);
    req_we[d] = we; req_funct3[d] = f3; req_addr[d] = addr; req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      fail_timeout($sformatf("accept d%0d", d));
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= lat_of(d) + 5; k++) begin
      @(negedge clk);
      if (!req_ready[d]) ready_low++;
      if (rsp_valid[d]) begin
        pulses++;
        if (lat < 0) begin
          lat = k; rd = rsp_rdata[d]; er = rsp_err[d];
        end
        req_valid[d] = 1'b0;
      end
      if (!hold && k == 1) begin
        req_valid[d] = 1'b0;
        req_we[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
      end
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] rd_m;
    logic        er_m;
    int lat, rl, pl;
    do_req(d, we, f3, addr, wdata, hold, rd, er, lat, rl, pl);
    model(d, we, f3, addr, wdata, rd_m, er_m);
    check($sformatf("rdata d%0d a=%08h f3=%0d we=%0d", d, addr, f3, we), rd, rd_m);
    check($sformatf("err d%0d a=%08h f3=%0d we=%0d", d, addr, f3, we), 32'(er), 32'(er_m));
    check($sformatf("latency d%0d", d), 32'(lat), 32'(lat_of(d) + 1));
    check($sformatf("ready_low d%0d", d), 32'(rl), 32'(lat_of(d) + 1));
    check($sformatf("pulses d%0d", d), 32'(pl), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    logic        er;
    int          pulses;

    tbl.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h11, 32'h0000007F, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD7FEF, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h20, 32'hCAFE1234, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h22, 32'h00008001, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h22, 32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h22, 32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h20, 32'h0,        32'h80011234, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h04, 32'h11223344, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h12, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 3'd1, 32'h05, 32'h0000AAAA, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h100, 32'h0,       32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd3, 32'h00, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h04, 32'h0,        32'h11223344, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'hFC, 32'h0BADF00D, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'hFC, 32'h0,        32'h0BADF00D, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'hFF, 32'h0,        32'h0000000B, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'hFE, 32'h0,        32'h00000BAD, 1'b0});
    tbl.push_back('{1'b1, 3'd4, 32'h10, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd6, 32'h00, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,  32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd1, 32'h23, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD7FEF, 1'b0});

    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_funct3[d] = 3'd0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset ready d%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset rdata d%0d", d), rsp_rdata[d], 32'h0);
      check($sformatf("reset err d%0d", d), 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b0;
    end

    // Give every word a known value so loads are fully predictable
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < DEPTH; w++)
        run(d, 1'b1, 3'd2, 32'(4 * w), $urandom, 1'b0, rd, er);

    // Directed vectors on the LATENCY=1 build
    foreach (tbl[i]) begin
      run(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 1'b0, rd, er);
      check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Randomized traffic on all builds
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;
        r = $urandom_range(0, 9);
        if (r < 8)       a = 32'($urandom_range(0, 255));
        else if (r == 8) a = 32'($urandom_range(256, 270));
        else             a = $urandom;
        if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
        else begin
          r = $urandom_range(0, 4);
          f3 = (r < 3) ? 3'(r) : 3'(r + 1);
        end
        run(d, 1'($urandom_range(0, 1)), f3, a, $urandom, 1'b0, rd, er);
      end
    end

    // Requester keeps req_valid high through WAIT: still only one accept and one pulse
    run(1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, rd, er);
    run(2, 1'b1, 3'd2, 32'h40, 32'h5A5AA5A5, 1'b1, rd, er);
    run(2, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, rd, er);
    check("hold readback", rd, 32'h5A5AA5A5);

    // Reset during WAIT discards the pending store and the response
    run(2, 1'b1, 3'd2, 32'h30, 32'hAAAA5555, 1'b0, rd, er);
    @(negedge clk);
    req_we[2] = 1'b1; req_funct3[2] = 3'd2; req_addr[2] = 32'h30;
    req_wdata[2] = 32'h12345678; req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("wait ready low", 32'(req_ready[2]), 32'd0);
    req_valid[2] = 1'b0;
    rst[2] = 1'b1;
    @(negedge clk);
    check("midrst ready", 32'(req_ready[2]), 32'd1);
    check("midrst rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("midrst rdata", rsp_rdata[2], 32'h0);
    check("midrst err", 32'(rsp_err[2]), 32'd0);
    rst[2] = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[2]) pulses++;
    end
    check("midrst no pulse", 32'(pulses), 32'd0);
    run(2, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, rd, er);
    check("midrst prior contents", rd, 32'hAAAA5555);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
